// File: rtl/v810_pkg.sv
// Shared types and helpers for the V810 external-bus target.
package v810_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } bus_tgt_state_t;

    localparam logic [7:0] BUS_TIMEOUT = 8'd255;

    function automatic logic [2:0] region_of(input logic [31:0] addr);
        return 3'(addr >> 24);
    endfunction

endpackage

// File: rtl/v810_bus_lane.sv
// Combinational lane steering for the bus target: backing-address alignment and
// 16-bit region read halfword selection replicated onto both CPU data halves.
module v810_bus_lane (
    input  logic        is_16b,
    input  logic [31:0] addr,
    input  logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] rd_data
);

    logic [15:0] half_sel;

    always_comb begin
        mem_addr = addr & (is_16b ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        rd_data  = is_16b ? {half_sel, half_sel} : rdata;
    end

endmodule

// File: rtl/v810_bus_target.sv
// V810 external-bus target: region decode, per-region wait states, one req/ack backing transfer.
// Define V810_BUS_TIMEOUT_EN to abandon unacknowledged accesses after BUS_TIMEOUT cycles and pulse BUS_ERR.
module v810_bus_target
    import v810_pkg::*;
#(
    parameter logic [15:0] REGION_WAIT = 16'h5400,
    parameter logic [7:0]  REGION_16B  = 8'hA0
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic [31:0] A,
    input  logic [31:0] D_O,
    output logic [31:0] D_I,
    input  logic [3:0]  BEn,
    input  logic [1:0]  ST,
    input  logic        DAn,
    input  logic        MRQn,
    input  logic        RW,
    input  logic        BCYSTn,
    output logic        READYn,
    output logic        SZRQn,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_WD,
    input  logic [31:0] MEM_RD,
    output logic [3:0]  MEM_BE,
    output logic        MEM_WR,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    output logic        BUS_ERR
);

    bus_tgt_state_t state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     be_q, be_d;
    logic           wr_q, wr_d;
    logic           is16_q, is16_d;
    logic           word_q, word_d;
    logic [1:0]     wait_q, wait_d;
    logic           ack_seen_q, ack_seen_d;
    logic [31:0]    rd_q, rd_d;
    logic           mem_req_q, mem_req_d;
    logic           readyn_q, readyn_d;
    logic           szrqn_q, szrqn_d;
    logic [31:0]    di_q, di_d;
`ifdef V810_BUS_TIMEOUT_EN
    logic [7:0]     to_q, to_d;
    logic           bus_err_q, bus_err_d;
`endif

    logic [2:0]  region;
    logic        ack_now;
    logic [31:0] lane_src;
    logic [31:0] lane_rd;
    logic        unused_reserved;

    assign unused_reserved = ^{ST, DAn};
    assign region          = region_of(A);
    assign ack_now         = (state_q == ACCESS) && mem_req_q && MEM_ACK;
    // Read data arriving in the terminating cycle bypasses the capture register.
    assign lane_src        = ack_now ? MEM_RD : rd_q;

    v810_bus_lane u_lane (
        .is_16b   (is16_q),
        .addr     (addr_q),
        .rdata    (lane_src),
        .mem_addr (MEM_A),
        .rd_data  (lane_rd)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        is16_d     = is16_q;
        word_d     = word_q;
        wait_d     = wait_q;
        ack_seen_d = ack_seen_q;
        rd_d       = rd_q;
        mem_req_d  = mem_req_q;
        di_d       = di_q;
        readyn_d   = 1'b1;
        szrqn_d    = 1'b1;
`ifdef V810_BUS_TIMEOUT_EN
        to_d       = to_q;
        bus_err_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!BCYSTn) begin
                    if (!MRQn) begin
                        state_d    = ACCESS;
                        addr_d     = A;
                        wdata_d    = D_O;
                        be_d       = ~BEn;
                        wr_d       = ~RW;
                        is16_d     = REGION_16B[region];
                        word_d     = (BEn == 4'b0000);
                        wait_d     = REGION_WAIT[{region, 1'b0} +: 2];
                        ack_seen_d = 1'b0;
                        mem_req_d  = 1'b1;
`ifdef V810_BUS_TIMEOUT_EN
                        to_d       = 8'd0;
`endif
                    end else begin
                        state_d  = DONE;
                        readyn_d = 1'b0;
                        di_d     = 32'd0;
                    end
                end
            end
            ACCESS: begin
                if (ack_now) begin
                    mem_req_d  = 1'b0;
                    rd_d       = MEM_RD;
                    ack_seen_d = 1'b1;
                end
                if (wait_q != 2'd0) begin
                    wait_d = wait_q - 2'd1;
                end
                // Writes carry no read data, so D_I keeps the last read result.
                if ((wait_q == 2'd0) && (ack_seen_q || ack_now)) begin
                    state_d  = DONE;
                    readyn_d = 1'b0;
                    szrqn_d  = ~(is16_q & word_q);
                    if (!wr_q) begin
                        di_d = lane_rd;
                    end
                end
`ifdef V810_BUS_TIMEOUT_EN
                else if (!ack_seen_q && !ack_now) begin
                    if (to_q == BUS_TIMEOUT) begin
                        state_d   = DONE;
                        readyn_d  = 1'b0;
                        mem_req_d = 1'b0;
                        di_d      = 32'hFFFF_FFFF;
                        bus_err_d = 1'b1;
                    end else begin
                        to_d = to_q + 8'd1;
                    end
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            wr_q       <= 1'b0;
            is16_q     <= 1'b0;
            word_q     <= 1'b0;
            wait_q     <= 2'd0;
            ack_seen_q <= 1'b0;
            rd_q       <= 32'd0;
            mem_req_q  <= 1'b0;
            readyn_q   <= 1'b1;
            szrqn_q    <= 1'b1;
            di_q       <= 32'd0;
`ifdef V810_BUS_TIMEOUT_EN
            to_q       <= 8'd0;
            bus_err_q  <= 1'b0;
`endif
        end else if (CE) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            is16_q     <= is16_d;
            word_q     <= word_d;
            wait_q     <= wait_d;
            ack_seen_q <= ack_seen_d;
            rd_q       <= rd_d;
            mem_req_q  <= mem_req_d;
            readyn_q   <= readyn_d;
            szrqn_q    <= szrqn_d;
            di_q       <= di_d;
`ifdef V810_BUS_TIMEOUT_EN
            to_q       <= to_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign D_I     = di_q;
    assign READYn  = readyn_q;
    assign SZRQn   = szrqn_q;
    assign MEM_WD  = wdata_q;
    assign MEM_BE  = be_q;
    assign MEM_WR  = wr_q;
    assign MEM_REQ = mem_req_q;
`ifdef V810_BUS_TIMEOUT_EN
    assign BUS_ERR = bus_err_q;
`else
    assign BUS_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_v810_bus_target.sv
// Self-checking bench for v810_bus_target: directed bus cycles plus randomized cycles checked
// against a cycle-count model of wait states, acknowledge latency and lane steering.
module tb_v810_bus_target;

    localparam logic [15:0] TB_REGION_WAIT = 16'h54C8;
    localparam logic [7:0]  TB_REGION_16B  = 8'hA0;
    localparam int          TB_TIMEOUT     = 255;

    logic        CLK;
    logic        RESn;
    logic        CE;
    logic [31:0] A;
    logic [31:0] D_O;
    logic [31:0] D_I;
    logic [3:0]  BEn;
    logic [1:0]  ST;
    logic        DAn;
    logic        MRQn;
    logic        RW;
    logic        BCYSTn;
    logic        READYn;
    logic        SZRQn;
    logic [31:0] MEM_A;
    logic [31:0] MEM_WD;
    logic [31:0] MEM_RD;
    logic [3:0]  MEM_BE;
    logic        MEM_WR;
    logic        MEM_REQ;
    logic        MEM_ACK;
    logic        BUS_ERR;

    int testsRun;
    int testsFailed;
    int txnId;

    // Expectations for the transaction currently in flight, indexed by CE cycle.
    int          expDone;
    int          expReqLast;
    bit          expMem;
    logic [31:0] expA;
    logic [31:0] expWd;
    logic [3:0]  expBe;
    logic        expWr;
    logic        expSz;
    logic        expErr;
    logic [31:0] expDiNew;
    logic [31:0] prevDi;

    v810_bus_target #(
        .REGION_WAIT (TB_REGION_WAIT),
        .REGION_16B  (TB_REGION_16B)
    ) dut (
        .CLK     (CLK),
        .RESn    (RESn),
        .CE      (CE),
        .A       (A),
        .D_O     (D_O),
        .D_I     (D_I),
        .BEn     (BEn),
        .ST      (ST),
        .DAn     (DAn),
        .MRQn    (MRQn),
        .RW      (RW),
        .BCYSTn  (BCYSTn),
        .READYn  (READYn),
        .SZRQn   (SZRQn),
        .MEM_A   (MEM_A),
        .MEM_WD  (MEM_WD),
        .MEM_RD  (MEM_RD),
        .MEM_BE  (MEM_BE),
        .MEM_WR  (MEM_WR),
        .MEM_REQ (MEM_REQ),
        .MEM_ACK (MEM_ACK),
        .BUS_ERR (BUS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input int c);
        string p;
        bit    reqExp;
        p      = $sformatf("t%0d c%0d", txnId, c);
        reqExp = expMem && (c >= 1) && (c <= expReqLast);
        checkOutput({p, " READYn"}, {31'd0, READYn}, {31'd0, (c != expDone)});
        checkOutput({p, " MEM_REQ"}, {31'd0, MEM_REQ}, {31'd0, reqExp});
        if (reqExp) begin
            checkOutput({p, " MEM_A"}, MEM_A, expA);
            checkOutput({p, " MEM_WD"}, MEM_WD, expWd);
            checkOutput({p, " MEM_BE"}, {28'd0, MEM_BE}, {28'd0, expBe});
            checkOutput({p, " MEM_WR"}, {31'd0, MEM_WR}, {31'd0, expWr});
        end
        checkOutput({p, " SZRQn"}, {31'd0, SZRQn}, {31'd0, (c == expDone) ? expSz : 1'b1});
        checkOutput({p, " BUS_ERR"}, {31'd0, BUS_ERR}, {31'd0, (c == expDone) ? expErr : 1'b0});
        checkOutput({p, " D_I"}, D_I, (c >= expDone) ? expDiNew : prevDi);
    endtask

    // ackAt: CE cycle (1 = first cycle after sampling) in which MEM_ACK is driven; 0 = never.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] ben, input logic rw,
                                 input logic mrqn, input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int ackAt, input bit ceToggle, input bit junk);
        int          region;
        int          waitStates;
        bit          is16;
        logic [15:0] half;
        region     = int'(addr[26:24]);
        waitStates = int'((TB_REGION_WAIT >> (2 * region)) & 16'h0003);
        is16       = TB_REGION_16B[region];
        expMem     = !mrqn;
        expA       = is16 ? {addr[31:1], 1'b0} : {addr[31:2], 2'b00};
        expWd      = wdata;
        expBe      = ~ben;
        expWr      = !rw;
        expErr     = 1'b0;
        expSz      = 1'b1;
        if (mrqn) begin
            expDone    = 1;
            expReqLast = 0;
            expDiNew   = 32'd0;
        end else begin
            if (ackAt > 0) begin
                expReqLast = ackAt;
                expDone    = 1 + ((waitStates + 1 > ackAt) ? waitStates + 1 : ackAt);
            end else begin
                expReqLast = TB_TIMEOUT + 1;
                expDone    = TB_TIMEOUT + 2;
                expErr     = 1'b1;
            end
            if (expErr) begin
                expDiNew = 32'hFFFF_FFFF;
            end else begin
                expSz = !(is16 && (ben == 4'b0000));
                if (rw) begin
                    half     = addr[1] ? rdata[31:16] : rdata[15:0];
                    expDiNew = is16 ? {half, half} : rdata;
                end else begin
                    expDiNew = prevDi;
                end
            end
        end

        for (int c = 0; c <= expDone + 1; c++) begin
            if (ceToggle) begin
                CE      = 1'b0;
                MEM_ACK = 1'($urandom);
                MEM_RD  = $urandom;
                BCYSTn  = 1'($urandom);
                MRQn    = 1'($urandom);
                @(negedge CLK);
                checkCycle(c);
                @(posedge CLK);
                #1;
            end
            CE      = 1'b1;
            BCYSTn  = (c == 0) ? 1'b0 : ((junk && c <= expDone && $urandom_range(0, 1) == 1) ? 1'b0 : 1'b1);
            MRQn    = (c == 0) ? mrqn : 1'($urandom);
            A       = (c == 0) ? addr : $urandom;
            BEn     = (c == 0) ? ben : 4'($urandom);
            RW      = (c == 0) ? rw : 1'($urandom);
            D_O     = (c == 0) ? wdata : $urandom;
            MEM_ACK = (!mrqn && c >= 1 && c == ackAt);
            MEM_RD  = (c == ackAt) ? rdata : $urandom;
            @(negedge CLK);
            checkCycle(c);
            @(posedge CLK);
            #1;
        end
        BCYSTn  = 1'b1;
        MRQn    = 1'b1;
        MEM_ACK = 1'b0;
        prevDi  = expDiNew;
        txnId++;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        txnId       = 0;
        prevDi      = 32'd0;
        RESn        = 1'b0;
        CE          = 1'b0;
        A           = 32'd0;
        D_O         = 32'd0;
        BEn         = 4'hF;
        ST          = 2'd0;
        DAn         = 1'b1;
        MRQn        = 1'b1;
        RW          = 1'b1;
        BCYSTn      = 1'b1;
        MEM_RD      = 32'd0;
        MEM_ACK     = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset READYn", {31'd0, READYn}, 32'd1);
        checkOutput("reset SZRQn", {31'd0, SZRQn}, 32'd1);
        checkOutput("reset MEM_REQ", {31'd0, MEM_REQ}, 32'd0);
        checkOutput("reset MEM_WR", {31'd0, MEM_WR}, 32'd0);
        checkOutput("reset BUS_ERR", {31'd0, BUS_ERR}, 32'd0);
        checkOutput("reset D_I", D_I, 32'd0);
        checkOutput("reset MEM_A", MEM_A, 32'd0);
        checkOutput("reset MEM_WD", MEM_WD, 32'd0);
        checkOutput("reset MEM_BE", {28'd0, MEM_BE}, 32'd0);
        RESn = 1'b1;
        @(posedge CLK);
        #1;

        // Region 6: 32-bit, one wait state, ACK one cycle after REQ -> READYn in cycle 3.
        applyStimulus(32'h0600_0000, 4'b0000, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 2, 1'b0, 1'b0);
        // Region 7: 16-bit, upper halfword replicated, sizing request on a full word.
        applyStimulus(32'h0700_0002, 4'b0000, 1'b1, 1'b0, 32'h0, 32'hBEEF_0000, 2, 1'b0, 1'b0);
        // Region 0 halfword write.
        applyStimulus(32'h0000_0102, 4'b1100, 1'b0, 1'b0, 32'h0000_AA55, 32'hDEAD_DEAD, 1, 1'b0, 1'b0);
        // Region 3 (three wait states) with ACK delayed to cycle 11 -> READYn in cycle 12.
        applyStimulus(32'h0300_0040, 4'b0000, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 11, 1'b0, 1'b0);
        applyStimulus(32'h0300_0044, 4'b0000, 1'b1, 1'b0, 32'h0, 32'h0BAD_CAFE, 11, 1'b1, 1'b0);
        // Early ACK hidden behind wait states; then a non-memory cycle.
        applyStimulus(32'h0300_0048, 4'b0000, 1'b1, 1'b0, 32'h0, 32'h5555_AAAA, 1, 1'b0, 1'b1);
        applyStimulus(32'h0100_0000, 4'b0000, 1'b1, 1'b1, 32'h0, 32'h0, 1, 1'b0, 1'b0);
        // 16-bit region 5, low halfword.
        applyStimulus(32'h0500_0000, 4'b1100, 1'b1, 1'b0, 32'h0, 32'h1111_2222, 3, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an access.
        CE     = 1'b1;
        BCYSTn = 1'b0;
        MRQn   = 1'b0;
        RW     = 1'b1;
        A      = 32'h0300_0010;
        BEn    = 4'b0000;
        @(posedge CLK);
        #1;
        BCYSTn = 1'b1;
        MRQn   = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("midrst pre MEM_REQ", {31'd0, MEM_REQ}, 32'd1);
        #2;
        RESn = 1'b0;
        #1;
        checkOutput("midrst MEM_REQ", {31'd0, MEM_REQ}, 32'd0);
        checkOutput("midrst READYn", {31'd0, READYn}, 32'd1);
        checkOutput("midrst D_I", D_I, 32'd0);
        checkOutput("midrst MEM_A", MEM_A, 32'd0);
        @(posedge CLK);
        #1;
        RESn   = 1'b1;
        prevDi = 32'd0;
        applyStimulus(32'h0300_0020, 4'b0000, 1'b1, 1'b0, 32'h0, 32'h7777_8888, 2, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            applyStimulus($urandom, 4'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                          $urandom, $urandom, $urandom_range(1, 6),
                          ($urandom_range(0, 3) == 0), 1'($urandom));
        end

`ifdef V810_BUS_TIMEOUT_EN
        applyStimulus(32'h0200_0000, 4'b0000, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        applyStimulus(32'h0600_0004, 4'b0000, 1'b1, 1'b0, 32'h0, 32'hA5A5_5A5A, 2, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
